// File: rtl/find_string_param.sv
// Symbol-entry buffer with a bit-serial pattern scanner that reports hit count and first hit positions.
// Define FIND_STRING_MASK_EN to add in_mask (0 bits are don't-care in the pattern compare).
module find_string_param #(
  parameter int unsigned SYM_W    = 4,
  parameter int unsigned MAX_SYMS = 10,
  parameter int unsigned PAT_W    = 4,
  parameter int unsigned MAX_HITS = 4,
  parameter int unsigned SCAN_DIV = 1,
  localparam int unsigned BITS  = MAX_SYMS * SYM_W,
  localparam int unsigned POS_W = $clog2(BITS + 1),
  localparam int unsigned CNT_W = $clog2(MAX_SYMS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SYM_W-1:0]          in_str,
  input  logic [PAT_W-1:0]          in_comp,
`ifdef FIND_STRING_MASK_EN
  input  logic [PAT_W-1:0]          in_mask,
`endif
  input  logic                      mode,
  input  logic                      submit,
  input  logic                      delete,
  input  logic                      done,
  input  logic                      roll_back,
  output logic [CNT_W-1:0]          sym_count,
  output logic                      busy,
  output logic                      result_valid,
  output logic [POS_W-1:0]          hit_count,
  output logic [MAX_HITS*POS_W-1:0] hit_pos,
  output logic                      hit_ovf
);

  localparam int unsigned DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned WIN_OFS = BITS - PAT_W + 1;

  typedef enum logic [1:0] {ENTRY, SCAN, RESULT} state_t;
  state_t state;

  logic [BITS-1:0]  buf_bits;
  logic [PAT_W-1:0] pat_q;
`ifdef FIND_STRING_MASK_EN
  logic [PAT_W-1:0] mask_q;
`endif
  logic             mode_q;
  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] last_pos;
  logic [POS_W-1:0] skip;
  logic [DIV_W-1:0] div_cnt;

  logic submit_s, submit_p, delete_s, delete_p, roll_s, roll_p, done_s;
  logic submit_press, delete_press, roll_press;
  logic full, start_scan, hit;
  logic [POS_W-1:0] tot_bits;
  logic [POS_W-1:0] scan_len;
  logic [PAT_W-1:0] window;

  // Buttons are registered twice so a press acts exactly once, one edge after it is sampled
  assign submit_press = submit_p & ~submit_s;
  assign delete_press = delete_p & ~delete_s;
  assign roll_press   = roll_p & ~roll_s;

  assign full       = (sym_count == CNT_W'(MAX_SYMS));
  assign start_scan = (state == ENTRY) ? (done_s || full) : roll_press;

  // Last valid start position; zero means there is nothing to scan
  assign tot_bits = POS_W'(sym_count) * POS_W'(SYM_W);
  assign scan_len = (tot_bits >= POS_W'(PAT_W)) ? (tot_bits - POS_W'(PAT_W) + POS_W'(1)) : '0;

  // Position 1 is the buffer MSB, so the window for pos sits WIN_OFS-pos bits above bit 0
  assign window = PAT_W'(buf_bits >> (WIN_OFS - 32'(pos)));

`ifdef FIND_STRING_MASK_EN
  assign hit = (((window ^ pat_q) & mask_q) == '0);
`else
  assign hit = (window == pat_q);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ENTRY;
      buf_bits     <= '0;
      sym_count    <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      hit_count    <= '0;
      hit_pos      <= '0;
      hit_ovf      <= 1'b0;
      pat_q        <= '0;
`ifdef FIND_STRING_MASK_EN
      mask_q       <= '0;
`endif
      mode_q       <= 1'b0;
      pos          <= '0;
      last_pos     <= '0;
      skip         <= '0;
      div_cnt      <= '0;
      submit_s     <= 1'b1;
      submit_p     <= 1'b1;
      delete_s     <= 1'b1;
      delete_p     <= 1'b1;
      roll_s       <= 1'b1;
      roll_p       <= 1'b1;
      done_s       <= 1'b0;
    end else begin
      submit_s <= submit;
      submit_p <= submit_s;
      delete_s <= delete;
      delete_p <= delete_s;
      roll_s   <= roll_back;
      roll_p   <= roll_s;
      done_s   <= done;

      if (start_scan) begin
        state        <= SCAN;
        busy         <= 1'b1;
        result_valid <= 1'b0;
        pat_q        <= in_comp;
`ifdef FIND_STRING_MASK_EN
        mask_q       <= in_mask;
`endif
        mode_q       <= mode;
        hit_count    <= '0;
        hit_pos      <= '0;
        hit_ovf      <= 1'b0;
        pos          <= POS_W'(1);
        last_pos     <= scan_len;
        skip         <= '0;
        div_cnt      <= '0;
      end else begin
        case (state)
          ENTRY: begin
            // Delete takes priority over a simultaneous submit
            if (delete_press) begin
              if (sym_count != '0) begin
                for (int i = 0; i < MAX_SYMS; i++) begin
                  if (sym_count == CNT_W'(i + 1)) buf_bits[(MAX_SYMS-1-i)*SYM_W +: SYM_W] <= '0;
                end
                sym_count <= sym_count - CNT_W'(1);
              end
            end else if (submit_press && !full) begin
              for (int i = 0; i < MAX_SYMS; i++) begin
                if (sym_count == CNT_W'(i)) buf_bits[(MAX_SYMS-1-i)*SYM_W +: SYM_W] <= in_str;
              end
              sym_count <= sym_count + CNT_W'(1);
            end
          end

          SCAN: begin
            if (last_pos == '0) begin
              state        <= RESULT;
              busy         <= 1'b0;
              result_valid <= 1'b1;
            end else if (div_cnt != DIV_W'(SCAN_DIV - 1)) begin
              div_cnt <= div_cnt + DIV_W'(1);
            end else begin
              div_cnt <= '0;
              if (skip != '0) begin
                skip <= skip - POS_W'(1);
              end else if (hit) begin
                hit_count <= hit_count + POS_W'(1);
                if (hit_count < POS_W'(MAX_HITS)) begin
                  for (int k = 0; k < MAX_HITS; k++) begin
                    if (hit_count == POS_W'(k)) hit_pos[k*POS_W +: POS_W] <= pos;
                  end
                end else begin
                  hit_ovf <= 1'b1;
                end
                if (mode_q) skip <= POS_W'(PAT_W - 1);
              end
              if (pos == last_pos) begin
                state        <= RESULT;
                busy         <= 1'b0;
                result_valid <= 1'b1;
              end else begin
                pos <= pos + POS_W'(1);
              end
            end
          end

          RESULT: begin
          end

          default: begin
            state <= ENTRY;
          end
        endcase
      end
    end
  end

endmodule
